// File: rtl/ppu_vblank_nmi_if.sv
// Bundle between the CPU register interface and the PPU frame timing block.
// Latency: none, plain wires grouped for port hygiene.
// Backpressure: none; dot_en and status_read are single-cycle strobes.
interface ppu_vblank_nmi_if;
  logic       dot_en;
  logic [7:0] ppuctrl_in;
  logic       rendering_en;
  logic       status_read;
  logic [8:0] dot;
  logic [8:0] scanline;
  logic       frame_odd;
  logic       vblank_flag;
  logic       nmi_n;

  // Register interface / timing source side.
  modport master (
    output dot_en, ppuctrl_in, rendering_en, status_read,
    input  dot, scanline, frame_odd, vblank_flag, nmi_n
  );

  // Frame timing block side.
  modport slave (
    input  dot_en, ppuctrl_in, rendering_en, status_read,
    output dot, scanline, frame_odd, vblank_flag, nmi_n
  );
endinterface

// File: rtl/ppu_vblank_nmi.sv
// PPU dot/scanline counter with VBlank flag and active-low NMI generation.
// Latency: counters and flag update 1 clk after dot_en; nmi_n 1 clk after flag/ctrl.
// Backpressure: none; dot_en is a free-running tick and status_read is never stalled.
module ppu_vblank_nmi #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ppu_vblank_nmi_if.slave      bus
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);
  localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);

  logic [8:0] dot_q;
  logic [8:0] line_q;
  logic       odd_q;
  logic       flag_q;
  logic       nmi_n_q;

  logic set_evt;
  logic clr_evt;
  logic odd_skip;
  logic unused_ctrl;

  // Flag edges happen on dot 1 of the VBlank-start and pre-render lines.
  assign set_evt  = bus.dot_en && (line_q == VBL_LINE) && (dot_q == 9'd1);
  assign clr_evt  = bus.dot_en && (line_q == PRE_LINE) && (dot_q == 9'd1);
  // Odd frames with rendering on drop the last pre-render dot; rendering_en
  // only matters on this exact tick.
  assign odd_skip = bus.dot_en && (line_q == PRE_LINE) && (dot_q == SKIP_DOT)
                    && odd_q && bus.rendering_en;

  // Only the NMI enable bit of PPUCTRL is meaningful here.
  assign unused_ctrl = ^bus.ppuctrl_in[6:0];

  // Dot/scanline/parity counters, advanced only on dot ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot_q  <= 9'd0;
      line_q <= 9'd0;
      odd_q  <= 1'b0;
    end else if (bus.dot_en) begin
      if (odd_skip) begin
        dot_q  <= 9'd0;
        line_q <= 9'd0;
        odd_q  <= 1'b0;
      end else if (dot_q == LAST_DOT) begin
        dot_q <= 9'd0;
        if (line_q == LAST_LINE) begin
          line_q <= 9'd0;
          odd_q  <= ~odd_q;
        end else begin
          line_q <= line_q + 9'd1;
        end
      end else begin
        dot_q <= dot_q + 9'd1;
      end
    end
  end

  // VBlank flag: a status read wins over a coincident set, suppressing that frame's NMI.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else if (bus.status_read) begin
      flag_q <= 1'b0;
    end else if (set_evt) begin
      flag_q <= 1'b1;
    end else if (clr_evt) begin
      flag_q <= 1'b0;
    end
  end

  // NMI follows the registered flag gated by PPUCTRL[7], so toggling the enable re-edges it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nmi_n_q <= 1'b1;
    end else begin
      nmi_n_q <= ~(flag_q & bus.ppuctrl_in[7]);
    end
  end

  assign bus.dot         = dot_q;
  assign bus.scanline    = line_q;
  assign bus.frame_odd   = odd_q;
  assign bus.vblank_flag = flag_q;
  assign bus.nmi_n       = nmi_n_q;

endmodule

// File: tb/tb_ppu_vblank_nmi.sv
// Bench for ppu_vblank_nmi: a reduced-geometry instance for frame-level behaviour
// plus a full-size instance sharing the stimulus for its counters.
// Every cycle the expected outputs of both are queued and popped after the edge.
module tb_ppu_vblank_nmi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ppu_vblank_nmi_if s_if();
  ppu_vblank_nmi_if b_if();

  ppu_vblank_nmi #(
    .DOTS_PER_LINE(24), .LINES_PER_FRAME(14), .VBLANK_LINE(10), .PRERENDER_LINE(13)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave)
  );

  ppu_vblank_nmi u_big (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  typedef struct {
    int k;
    int dot;
    int line;
    int odd;
    int flag;
    int nmi;
  } exp_t;

  exp_t sb[$];

  int p_dots [2] = '{24, 341};
  int p_lines[2] = '{14, 262};
  int p_vbl  [2] = '{10, 241};
  int p_pre  [2] = '{13, 261};

  int m_dot[2], m_line[2], m_odd[2], m_flag[2], m_nmi[2];

  int vectors     = 0;
  int miscompares = 0;
  bit nmi_low_seen;

  task automatic chk(input string tag, input logic [31:0] got, input int want);
    vectors++;
    if (got !== 32'(want)) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference behaviour of one instance for one clock with the given inputs.
  task automatic model_step(input int k, input bit en, input logic [7:0] ctrl,
                            input bit ren, input bit rd);
    int nf, nn;
    if (!rst_n) begin
      m_dot[k] = 0; m_line[k] = 0; m_odd[k] = 0; m_flag[k] = 0; m_nmi[k] = 1;
    end else begin
      nn = (m_flag[k] == 1 && ctrl[7]) ? 0 : 1;
      nf = m_flag[k];
      if (rd) nf = 0;
      else if (en && m_line[k] == p_vbl[k] && m_dot[k] == 1) nf = 1;
      else if (en && m_line[k] == p_pre[k] && m_dot[k] == 1) nf = 0;
      if (en) begin
        if (m_dot[k] == p_dots[k] - 2 && m_line[k] == p_pre[k] && m_odd[k] == 1 && ren) begin
          m_dot[k] = 0; m_line[k] = 0; m_odd[k] = 0;
        end else if (m_dot[k] == p_dots[k] - 1) begin
          m_dot[k] = 0;
          if (m_line[k] == p_lines[k] - 1) begin
            m_line[k] = 0;
            m_odd[k]  = 1 - m_odd[k];
          end else begin
            m_line[k] = m_line[k] + 1;
          end
        end else begin
          m_dot[k] = m_dot[k] + 1;
        end
      end
      m_flag[k] = nf;
      m_nmi[k]  = nn;
    end
    sb.push_back('{k, m_dot[k], m_line[k], m_odd[k], m_flag[k], m_nmi[k]});
  endtask

  // Drive one clock of stimulus (called at negedge), queue expectations, compare after the edge.
  task automatic step(input bit en, input logic [7:0] ctrl, input bit ren, input bit rd);
    exp_t e;
    s_if.dot_en = en; s_if.ppuctrl_in = ctrl; s_if.rendering_en = ren; s_if.status_read = rd;
    b_if.dot_en = en; b_if.ppuctrl_in = ctrl; b_if.rendering_en = ren; b_if.status_read = rd;
    for (int k = 0; k < 2; k++) model_step(k, en, ctrl, ren, rd);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.k == 0) begin
        chk("s.dot",  32'(s_if.dot),         e.dot);
        chk("s.line", 32'(s_if.scanline),    e.line);
        chk("s.odd",  32'(s_if.frame_odd),   e.odd);
        chk("s.flag", 32'(s_if.vblank_flag), e.flag);
        chk("s.nmi",  32'(s_if.nmi_n),       e.nmi);
      end else begin
        chk("b.dot",  32'(b_if.dot),         e.dot);
        chk("b.line", 32'(b_if.scanline),    e.line);
        chk("b.odd",  32'(b_if.frame_odd),   e.odd);
        chk("b.flag", 32'(b_if.vblank_flag), e.flag);
        chk("b.nmi",  32'(b_if.nmi_n),       e.nmi);
      end
    end
    if (s_if.nmi_n === 1'b0) nmi_low_seen = 1'b1;
    @(negedge clk);
  endtask

  // Tick the small instance until its next tick would land on (line, dot).
  task automatic run_to(input int line, input int dot, input logic [7:0] ctrl, input bit ren);
    int n = 0;
    while (!(m_line[0] == line && m_dot[0] == dot) && n < 2000) begin
      step(1'b1, ctrl, ren, 1'b0);
      n++;
    end
    chk("run_to.reached", 32'(m_line[0] == line && m_dot[0] == dot), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    s_if.dot_en = 1'b0; s_if.ppuctrl_in = 8'h00; s_if.rendering_en = 1'b0; s_if.status_read = 1'b0;
    b_if.dot_en = 1'b0; b_if.ppuctrl_in = 8'h00; b_if.rendering_en = 1'b0; b_if.status_read = 1'b0;
    nmi_low_seen = 1'b0;
    @(negedge clk);

    // Reset state.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b1, 1'b1);
    chk("rst.dot",  32'(s_if.dot), 0);
    chk("rst.line", 32'(s_if.scanline), 0);
    chk("rst.odd",  32'(s_if.frame_odd), 0);
    chk("rst.flag", 32'(s_if.vblank_flag), 0);
    chk("rst.nmi",  32'(s_if.nmi_n), 1);
    rst_n = 1'b1;

    // One full even frame without rendering: 24*14 = 336 ticks back to (0,0), odd parity.
    for (int i = 0; i < 336; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("frame.dot",  32'(s_if.dot), 0);
    chk("frame.line", 32'(s_if.scanline), 0);
    chk("frame.odd",  32'(s_if.frame_odd), 1);
    chk("big.dot336", 32'(b_if.dot), 336);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("big.wrap.dot",  32'(b_if.dot), 0);
    chk("big.wrap.line", 32'(b_if.scanline), 1);

    // VBlank set with NMI enabled, then cleared on the pre-render line.
    run_to(10, 1, 8'h80, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    chk("set.flag", 32'(s_if.vblank_flag), 1);
    chk("set.nmi_lag", 32'(s_if.nmi_n), 1);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    chk("set.nmi", 32'(s_if.nmi_n), 0);
    run_to(13, 1, 8'h80, 1'b0);
    chk("vbl.hold", 32'(s_if.vblank_flag), 1);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    chk("clr.flag", 32'(s_if.vblank_flag), 0);
    chk("clr.nmi_lag", 32'(s_if.nmi_n), 0);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    chk("clr.nmi", 32'(s_if.nmi_n), 1);

    // Odd frame, rendering off: dot 340-equivalent is visited.
    run_to(13, 22, 8'h00, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    chk("noskip.dot",  32'(s_if.dot), 23);
    chk("noskip.line", 32'(s_if.scanline), 13);
    run_to(0, 0, 8'h00, 1'b0);
    chk("even.odd", 32'(s_if.frame_odd), 0);

    // Status read during VBlank: flag seen as 1 in the read cycle, then cleared, NMI released.
    run_to(10, 1, 8'h80, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    chk("rd.nmi_pre", 32'(s_if.nmi_n), 0);
    s_if.status_read = 1'b1;
    #1;
    chk("rd.flag_in_cycle", 32'(s_if.vblank_flag), 1);
    step(1'b0, 8'h80, 1'b0, 1'b1);
    chk("rd.flag_after", 32'(s_if.vblank_flag), 0);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    chk("rd.nmi_release", 32'(s_if.nmi_n), 1);
    run_to(13, 0, 8'h80, 1'b0);
    chk("rd.no_reset", 32'(s_if.vblank_flag), 0);
    run_to(0, 0, 8'h80, 1'b0);

    // Read coincident with the set tick: no flag and no NMI for the whole frame.
    nmi_low_seen = 1'b0;
    run_to(10, 1, 8'h80, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b1);
    chk("race.flag", 32'(s_if.vblank_flag), 0);
    run_to(13, 22, 8'h80, 1'b0);
    chk("race.nmi_never", 32'(nmi_low_seen), 0);
    chk("skip.pre_odd", 32'(s_if.frame_odd), 1);

    // Odd frame with rendering on: (13,22) tick jumps straight to (0,0).
    step(1'b1, 8'h00, 1'b1, 1'b0);
    chk("skip.dot",  32'(s_if.dot), 0);
    chk("skip.line", 32'(s_if.scanline), 0);
    chk("skip.odd",  32'(s_if.frame_odd), 0);

    // NMI enable toggling while the flag stays set.
    run_to(11, 0, 8'h00, 1'b0);
    chk("tog.flag", 32'(s_if.vblank_flag), 1);
    chk("tog.nmi_off", 32'(s_if.nmi_n), 1);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    chk("tog.nmi_on", 32'(s_if.nmi_n), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tog.nmi_off2", 32'(s_if.nmi_n), 1);
    step(1'b0, 8'h80, 1'b0, 1'b0);
    chk("tog.nmi_reedge", 32'(s_if.nmi_n), 0);
    step(1'b0, 8'h7F, 1'b0, 1'b0);
    chk("tog.low_bits", 32'(s_if.nmi_n), 1);
    step(1'b0, 8'h80, 1'b0, 1'b0);

    // Reset mid-VBlank with every other input active.
    rst_n = 1'b0;
    step(1'b1, 8'h80, 1'b1, 1'b1);
    chk("mid_rst.dot",  32'(s_if.dot), 0);
    chk("mid_rst.line", 32'(s_if.scanline), 0);
    chk("mid_rst.odd",  32'(s_if.frame_odd), 0);
    chk("mid_rst.flag", 32'(s_if.vblank_flag), 0);
    chk("mid_rst.nmi",  32'(s_if.nmi_n), 1);
    rst_n = 1'b1;
    step(1'b0, 8'h80, 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    chk("post_rst.nmi", 32'(s_if.nmi_n), 1);
    chk("post_rst.dot", 32'(s_if.dot), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppu_vblank_nmi.md
# ppu_vblank_nmi

PPU frame timing and vertical-blank/NMI generator. Tracks the current dot and scanline, raises the PPUSTATUS VBlank flag at the start of vertical blank, and drives the active-low NMI line to the CPU when PPUCTRL bit 7 is set. Consumes the PPUCTRL byte directly and the PPUSTATUS read strobe from the CPU register interface. Supplies the VBlank status bit back to that interface.

## Interface
- DOTS_PER_LINE, 341, dots per scanline
- LINES_PER_FRAME, 262, scanlines per frame
- VBLANK_LINE, 241, scanline on which VBlank starts
- PRERENDER_LINE, 261, scanline on which VBlank ends; odd-frame dot skip happens here
- clk  in  1  PPU clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- dot_en  in  1  one-cycle tick; advances timing by one PPU dot
- ppuctrl_in  in  8  current PPUCTRL value; only bit 7 (NMI enable) is used
- rendering_en  in  1  background or sprite rendering enabled (from PPUMASK)
- status_read  in  1  one-cycle strobe: CPU read of PPUSTATUS ($2002)
- dot  out  9  current dot, 0..DOTS_PER_LINE-1
- scanline  out  9  current scanline, 0..LINES_PER_FRAME-1
- frame_odd  out  1  current frame parity
- vblank_flag  out  1  PPUSTATUS bit 7 value presented to the CPU read mux
- nmi_n  out  1  NMI to CPU, active low

## Operation
- Reset (rst_n=0 at posedge) forces dot=0, scanline=0, frame_odd=0, vblank_flag=0, nmi_n=1. Reset wins over every other event.
- Counters change only on cycles with dot_en=1:
  - Normal: dot increments.
  - At dot=DOTS_PER_LINE-1: dot→0 and scanline increments.
  - At scanline=LINES_PER_FRAME-1 on that wrap: scanline→0 and frame_odd toggles.
- Odd-frame skip: applies when dot_en=1, dot=DOTS_PER_LINE-2 (339), scanline=PRERENDER_LINE, frame_odd=1 and rendering_en=1.
  - dot→0, scanline→0, frame_odd→0; dot 340 is skipped.
  - rendering_en is sampled on that cycle only.
- Set event: dot_en=1 with (scanline,dot)=(VBLANK_LINE,1). vblank_flag→1 on that edge.
- Clear event: dot_en=1 with (scanline,dot)=(PRERENDER_LINE,1). vblank_flag→0.
- status_read=1: vblank_flag→0 on that edge. The CPU samples vblank_flag combinationally in the read cycle, before the clear.
- Simultaneous status_read and set event: flag stays 0. The read returns 0, and no NMI occurs for that frame.
- Simultaneous status_read and clear event: flag→0.
- nmi_n is registered: nmi_n ← ~(vblank_flag & ppuctrl_in[7]).
  - Clearing bit 7 during VBlank deasserts NMI.
  - Setting bit 7 while the flag is still 1 re-asserts NMI, giving a new falling edge.
- Only ppuctrl_in[7] affects behaviour; other bits are ignored.

## Timing
- Counter and flag updates: one clk after the qualifying dot_en cycle.
- nmi_n: one clk after vblank_flag or ppuctrl_in[7] changes. Set event to nmi_n low is 2 clk.
- Frame length: 89342 dot_en ticks. Odd frame with rendering_en at the skip point: 89341.
- status_read with dot_en=0 still clears the flag. dot_en does not gate reads.
- Reset mid-frame: next frame starts from (0,0), even parity, no NMI pending.

## Test plan
- Reset then 89342 dot_en ticks, rendering_en=0 → (scanline,dot) returns to (0,0), frame_odd=1.
- Advance to (241,1) tick with ppuctrl_in=8'h80 → vblank_flag=1 next clk, nmi_n=0 the clk after. Advance to (261,1) tick → vblank_flag=0, nmi_n=1 one clk later.
- In VBlank with ppuctrl_in=8'h80, pulse status_read → vblank_flag reads 1 in that cycle, then 0; nmi_n returns to 1 one clk later. No re-set until the next frame.
- status_read coincident with the (241,1) tick → vblank_flag stays 0 and nmi_n stays 1 for the whole frame.
- frame_odd=1, rendering_en=1, tick at (261,339) → next (0,0). Same with rendering_en=0 → next (261,340).
- In VBlank with ppuctrl_in=8'h00, switch to 8'h80 → nmi_n 1→0 after one clk. Back to 8'h00 → nmi_n=1. Assert rst_n=0 mid-VBlank → all outputs at reset values after one clk.
